// File: rtl/chan_cfg_pkg.sv
// Shared types and helpers for the channelizer configuration/reset sequencer.
package chan_cfg_pkg;

  typedef enum logic [1:0] {
    S_HOLD,
    S_CONFIG,
    S_RUN
  } state_e;

  localparam int NFFT_MIN         = 3;
  localparam int DEFAULT_FFT_SIZE = 8;

  // Index of the highest set bit; equals log2 for a power-of-two argument.
  function automatic logic [4:0] clog2_pow2(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/chan_log2_enc.sv
// Combinational FFT-size classifier: power-of-two test, log2 and legal-range flag.
module chan_log2_enc
  import chan_cfg_pkg::*;
#(
  parameter int MAX_FFT_LOG2   = 11,
  parameter int FFT_SIZE_WIDTH = 12
) (
  input  logic [FFT_SIZE_WIDTH-1:0] size_i,
  output logic                      is_pow2_o,
  output logic [4:0]                log2_o,
  output logic                      in_range_o
);

  logic [31:0] size_ext;

  always_comb begin
    size_ext   = 32'(size_i);
    is_pow2_o  = (size_ext != 32'd0) && ((size_ext & (size_ext - 32'd1)) == 32'd0);
    log2_o     = clog2_pow2(size_ext);
    in_range_o = (size_ext >= 32'(DEFAULT_FFT_SIZE)) &&
                 (size_ext <= (32'd1 << MAX_FFT_LOG2));
  end

endmodule

// File: rtl/chan_cfg_seq.sv
// Configuration and reset sequencer for the M/2 channelizer datapath.
// Optional macro CHAN_CFG_STATS_EN adds saturating handshake and error counters.
module chan_cfg_seq
  import chan_cfg_pkg::*;
#(
  parameter int MAX_FFT_LOG2   = 11,
  parameter int FFT_SIZE_WIDTH = 12,
  parameter int PL_WIDTH       = 16,
  parameter int RESET_CYCLES   = 8,
  parameter int CFG_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      sync_reset_n,
  input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
  input  logic [PL_WIDTH-1:0]       payload_length,
  output logic                      reset_int,
  output logic                      reset_int_n,
  output logic [FFT_SIZE_WIDTH-1:0] fft_size_s,
  output logic [PL_WIDTH-1:0]       payload_length_m1,
  output logic                      m_axis_config_tvalid,
  output logic [CFG_WIDTH-1:0]      m_axis_config_tdata,
  input  logic                      m_axis_config_tready,
  output logic                      cfg_busy,
  output logic                      cfg_error
`ifdef CHAN_CFG_STATS_EN
  ,
  output logic [15:0]               cfg_count,
  output logic [15:0]               err_count
`endif
);

  localparam int                CNT_W      = $clog2(RESET_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(RESET_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      reset_int_q, reset_int_n_q;
  logic [FFT_SIZE_WIDTH-1:0] fft_q, acc_fft_q, fft_size_s_q;
  logic [PL_WIDTH-1:0]       pl_q, acc_pl_q, pl_m1_q;
  logic [4:0]                nfft_q;
  logic                      cfg_error_q;
  logic                      fft_chg, pl_chg, chg;
  logic                      enc_pow2, enc_range, fft_legal;
  logic [4:0]                enc_log2;

  chan_log2_enc #(
    .MAX_FFT_LOG2  (MAX_FFT_LOG2),
    .FFT_SIZE_WIDTH(FFT_SIZE_WIDTH)
  ) u_log2_enc (
    .size_i    (fft_q),
    .is_pow2_o (enc_pow2),
    .log2_o    (enc_log2),
    .in_range_o(enc_range)
  );

  // A zero size is "no request" and never counts as a change.
  assign fft_chg   = (fft_q != '0) && (fft_q != acc_fft_q);
  assign pl_chg    = (pl_q != acc_pl_q);
  assign chg       = fft_chg || pl_chg;
  assign fft_legal = enc_pow2 && enc_range;

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      fft_q <= '0;
      pl_q  <= '0;
    end else begin
      fft_q <= fft_size;
      pl_q  <= payload_length;
    end
  end

  // reset_int and its inverse come from the next state so both move on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      state_q       <= S_HOLD;
      cnt_q         <= CNT_RELOAD;
      reset_int_q   <= 1'b1;
      reset_int_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reset_int_q   <= (state_d == S_HOLD);
      reset_int_n_q <= (state_d != S_HOLD);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_HOLD: begin
        if (chg)                cnt_d   = CNT_RELOAD;
        else if (cnt_q == '0)   state_d = S_CONFIG;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      S_CONFIG: begin
        if (chg) begin
          state_d = S_HOLD;
          cnt_d   = CNT_RELOAD;
        end else if (m_axis_config_tready) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (chg) begin
          state_d = S_HOLD;
          cnt_d   = CNT_RELOAD;
        end
      end
      default: begin
        state_d = S_HOLD;
        cnt_d   = CNT_RELOAD;
      end
    endcase
  end

  always_comb begin
    m_axis_config_tvalid     = (state_q == S_CONFIG);
    m_axis_config_tdata      = '0;
    m_axis_config_tdata[4:0] = nfft_q;
    cfg_busy                 = (state_q != S_RUN);
  end

  // Requests are validated and latched on the edge that detects the change.
  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      acc_fft_q    <= '0;
      acc_pl_q     <= '0;
      fft_size_s_q <= FFT_SIZE_WIDTH'(DEFAULT_FFT_SIZE);
      nfft_q       <= 5'(NFFT_MIN);
      cfg_error_q  <= 1'b0;
      pl_m1_q      <= '0;
    end else if (chg) begin
      acc_pl_q <= pl_q;
      pl_m1_q  <= (pl_q == '0) ? '0 : pl_q - 1'b1;
      if (fft_chg) begin
        acc_fft_q <= fft_q;
        if (fft_legal) begin
          fft_size_s_q <= fft_q;
          nfft_q       <= enc_log2;
          cfg_error_q  <= 1'b0;
        end else begin
          fft_size_s_q <= FFT_SIZE_WIDTH'(DEFAULT_FFT_SIZE);
          nfft_q       <= 5'(NFFT_MIN);
          cfg_error_q  <= 1'b1;
        end
      end
    end
  end

`ifdef CHAN_CFG_STATS_EN
  logic [15:0] cfg_count_q, err_count_q;

  always_ff @(posedge clk) begin
    if (!sync_reset_n) begin
      cfg_count_q <= '0;
      err_count_q <= '0;
    end else begin
      if (m_axis_config_tvalid && m_axis_config_tready && (cfg_count_q != 16'hFFFF))
        cfg_count_q <= cfg_count_q + 16'd1;
      if (fft_chg && !fft_legal && (err_count_q != 16'hFFFF))
        err_count_q <= err_count_q + 16'd1;
    end
  end

  assign cfg_count = cfg_count_q;
  assign err_count = err_count_q;
`endif

  assign reset_int         = reset_int_q;
  assign reset_int_n       = reset_int_n_q;
  assign fft_size_s        = fft_size_s_q;
  assign payload_length_m1 = pl_m1_q;
  assign cfg_error         = cfg_error_q;

endmodule

// File: tb/tb_chan_cfg_seq.sv
// Self-checking bench for chan_cfg_seq: directed plan steps followed by random traffic
// against a cycle-numbered reference model (covers CHAN_CFG_STATS_EN when defined).
module tb_chan_cfg_seq;

  localparam int MAXL   = 11;
  localparam int FW     = 13;
  localparam int PW     = 16;
  localparam int RC     = 8;
  localparam int CW     = 16;
  localparam int P_HOLD = 0;
  localparam int P_CFG  = 1;
  localparam int P_RUN  = 2;

  logic          clk = 1'b0;
  logic          syncResetN;
  logic [FW-1:0] fftSize;
  logic [PW-1:0] payloadLength;
  logic          tready;

  wire           resetInt, resetIntN, tvalid, busy, cfgError;
  wire [FW-1:0]  fftSizeS;
  wire [PW-1:0]  plM1;
  wire [CW-1:0]  tdata;
`ifdef CHAN_CFG_STATS_EN
  wire [15:0]    cfgCount, errCount;
`endif

  always #5 clk = ~clk;

  chan_cfg_seq #(
    .MAX_FFT_LOG2  (MAXL),
    .FFT_SIZE_WIDTH(FW),
    .PL_WIDTH      (PW),
    .RESET_CYCLES  (RC),
    .CFG_WIDTH     (CW)
  ) dut (
    .clk                 (clk),
    .sync_reset_n        (syncResetN),
    .fft_size            (fftSize),
    .payload_length      (payloadLength),
    .reset_int           (resetInt),
    .reset_int_n         (resetIntN),
    .fft_size_s          (fftSizeS),
    .payload_length_m1   (plM1),
    .m_axis_config_tvalid(tvalid),
    .m_axis_config_tdata (tdata),
    .m_axis_config_tready(tready),
    .cfg_busy            (busy),
    .cfg_error           (cfgError)
`ifdef CHAN_CFG_STATS_EN
    ,
    .cfg_count           (cfgCount),
    .err_count           (errCount)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  // Model: the sequence is described by edge numbers rather than a counter.
  int edgeNo, holdEnd, phase, accF, accP, regF, regP;
  int expSize, expNfft, expErr, expPl, cfgCnt, errCnt;
  bit configured;

  int fftTable[14] = '{0, 8, 16, 64, 256, 1024, 2048, 4096, 1000, 4, 2, 12, 0, 32};

  function automatic int modelLog2(int size);
    for (int k = 3; k <= MAXL; k++) begin
      if (size == (1 << k)) return k;
    end
    return -1;
  endfunction

  task automatic modelReset();
    edgeNo     = 0;
    holdEnd    = RC;
    phase      = P_HOLD;
    configured = 1'b0;
    accF = 0; accP = 0; regF = 0; regP = 0;
    expSize = 8; expNfft = 3; expErr = 0; expPl = 0;
    cfgCnt = 0; errCnt = 0;
  endtask

  task automatic modelEdge(bit rdy);
    bit fChg, pChg, handshake;
    int k;
    fChg      = (regF != 0) && (regF != accF);
    pChg      = (regP != accP);
    handshake = (phase == P_CFG) && rdy;
    if (handshake && cfgCnt < 65535) cfgCnt++;
    if (fChg || pChg) begin
      holdEnd    = edgeNo + RC;
      configured = 1'b0;
      accP       = regP;
      expPl      = (regP == 0) ? 0 : regP - 1;
      if (fChg) begin
        accF = regF;
        k    = modelLog2(regF);
        if (k >= 0) begin
          expSize = regF; expNfft = k; expErr = 0;
        end else begin
          expSize = 8; expNfft = 3; expErr = 1;
          if (errCnt < 65535) errCnt++;
        end
      end
    end else if (handshake) begin
      configured = 1'b1;
    end
    if (edgeNo < holdEnd)  phase = P_HOLD;
    else if (!configured)  phase = P_CFG;
    else                   phase = P_RUN;
  endtask

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("reset_int",   32'(resetInt),  32'(phase == P_HOLD));
    checkOutput("reset_int_n", 32'(resetIntN), 32'(phase != P_HOLD));
    checkOutput("tvalid",      32'(tvalid),    32'(phase == P_CFG));
    checkOutput("tdata",       32'(tdata),     32'(expNfft));
    checkOutput("cfg_busy",    32'(busy),      32'(phase != P_RUN));
    checkOutput("fft_size_s",  32'(fftSizeS),  32'(expSize));
    checkOutput("pl_m1",       32'(plM1),      32'(expPl));
    checkOutput("cfg_error",   32'(cfgError),  32'(expErr));
`ifdef CHAN_CFG_STATS_EN
    checkOutput("cfg_count",   32'(cfgCount),  32'(cfgCnt));
    checkOutput("err_count",   32'(errCount),  32'(errCnt));
`endif
  endtask

  task automatic tick();
    int inF, inP;
    bit inR, inRst;
    inF   = int'(fftSize);
    inP   = int'(payloadLength);
    inR   = tready;
    inRst = syncResetN;
    @(posedge clk);
    if (!inRst) begin
      modelReset();
    end else begin
      edgeNo++;
      modelEdge(inR);
      regF = inF;
      regP = inP;
    end
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(int f, int p, bit r, int n);
    fftSize       = FW'(f);
    payloadLength = PW'(p);
    tready        = r;
    repeat (n) tick();
  endtask

  initial begin
    syncResetN    = 1'b0;
    fftSize       = '0;
    payloadLength = '0;
    tready        = 1'b0;
    modelReset();
    $display("[TB] reset");
    repeat (3) tick();

    $display("[TB] release with no request");
    syncResetN = 1'b1;
    applyStimulus(0, 0, 1'b1, 12);

    $display("[TB] size 2048, then illegal 1000 and 4096, then 256");
    applyStimulus(2048, 0, 1'b1, 14);
    applyStimulus(1000, 0, 1'b1, 14);
    applyStimulus(4096, 0, 1'b1, 14);
    applyStimulus(256,  0, 1'b1, 14);

    $display("[TB] payload change three cycles into hold");
    applyStimulus(256, 100, 1'b1, 4);
    applyStimulus(256, 37,  1'b1, 14);

    $display("[TB] config stalled by tready, change mid-stall");
    applyStimulus(512, 37, 1'b0, 11);
    applyStimulus(512, 37, 1'b0, 10);
    applyStimulus(64,  37, 1'b0, 20);
    applyStimulus(64,  37, 1'b1, 4);

    $display("[TB] zero size is no request");
    applyStimulus(0, 37, 1'b1, 5);

    $display("[TB] reset mid-sequence");
    applyStimulus(128, 5, 1'b0, 4);
    syncResetN = 1'b0;
    applyStimulus(128, 5, 1'b0, 2);
    syncResetN = 1'b1;
    applyStimulus(128, 5, 1'b1, 12);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)  fftSize       = FW'(fftTable[$urandom_range(0, 13)]);
      if ($urandom_range(0, 9) == 0)  payloadLength = PW'($urandom_range(0, 6));
      tready     = 1'($urandom_range(0, 1));
      syncResetN = ($urandom_range(0, 149) != 0);
      tick();
    end
    syncResetN = 1'b1;
    applyStimulus(16, 9, 1'b1, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
